// File: rtl/uart_pkg.sv
// Shared UART receive types, default parameters and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DATA_BITS    = 8;
  localparam int MAX_DATA_BITS    = 9;

  // Returns the parity bit a transmitter would append to data.
  function automatic logic par_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with half-bit and full-bit compare strobes.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign half_tick = (count == HALF_LAST);
  assign full_tick = (count == FULL_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: times bit centres, assembles data LSB first and
// reports each frame as a valid, frame-error or parity-error pulse.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_en,
  input  logic                 i_start_signal,
  input  logic                 i_rx_in,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic ODD_SEL = (PARITY_ODD != 0);

  rx_state_e state, state_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bad;
  logic                 half_tick, full_tick, timer_clear;
  logic                 expected_par;

  assign expected_par = par_calc(MAX_DATA_BITS'(shift_reg), ODD_SEL);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (timer_clear),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // The timer is held clear in IDLE so START always begins counting from 0.
  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    if (!i_rx_en) begin
      state_nxt   = IDLE;
      timer_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          timer_clear = 1'b1;
          if (i_start_signal) state_nxt = START;
        end
        START: begin
          if (half_tick) begin
            timer_clear = 1'b1;
            state_nxt   = i_rx_in ? IDLE : DATA;
          end
        end
        DATA: begin
          if (full_tick) begin
            timer_clear = 1'b1;
            if (bit_idx == LAST_IDX) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (full_tick) begin
            timer_clear = 1'b1;
            state_nxt   = STOP;
          end
        end
        STOP: begin
          if (full_tick) begin
            timer_clear = 1'b1;
            state_nxt   = IDLE;
          end
        end
        default: begin
          timer_clear = 1'b1;
          state_nxt   = IDLE;
        end
      endcase
    end
  end

  // Shifting in from the top leaves the first received bit at bit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      parity_bad   <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_busy       <= (state_nxt != IDLE);
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      if (!i_rx_en) begin
        bit_idx    <= '0;
        parity_bad <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_idx    <= '0;
            parity_bad <= 1'b0;
          end
          DATA: begin
            if (full_tick) begin
              shift_reg <= {i_rx_in, shift_reg[DATA_BITS-1:1]};
              bit_idx   <= bit_idx + IDX_W'(1);
            end
          end
          PARITY: begin
            if (full_tick) parity_bad <= (expected_par != i_rx_in);
          end
          STOP: begin
            if (full_tick) begin
              o_rx_data <= shift_reg;
              if (!i_rx_in)        o_frame_err  <= 1'b1;
              else if (parity_bad) o_parity_err <= 1'b1;
              else                 o_rx_valid   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit, with and without parity.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_en;
  logic       start_sig;
  logic       rx_line;

  logic [7:0] rx_data, p_rx_data;
  logic       rx_valid, frame_err, parity_err, busy;
  logic       p_rx_valid, p_frame_err, p_parity_err, p_busy;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int start_cycle = 0;

  int n_valid = 0, n_ferr = 0, n_perr = 0, valid_cycle = 0;
  int p_valid = 0, p_ferr = 0, p_perr = 0;
  logic [7:0] data_last = 8'h00, data_prev = 8'h00;

  int b_valid, b_ferr, b_perr, bp_valid, bp_ferr, bp_perr;

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_en(rx_en), .i_start_signal(start_sig),
    .i_rx_in(rx_line), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_frame_err(frame_err), .o_parity_err(parity_err), .o_busy(busy)
  );

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_par (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_en(rx_en), .i_start_signal(start_sig),
    .i_rx_in(rx_line), .o_rx_data(p_rx_data), .o_rx_valid(p_rx_valid),
    .o_frame_err(p_frame_err), .o_parity_err(p_parity_err), .o_busy(p_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid     <= n_valid + 1;
      valid_cycle <= cycle;
      data_prev   <= data_last;
      data_last   <= rx_data;
    end
    if (frame_err)    n_ferr  <= n_ferr + 1;
    if (parity_err)   n_perr  <= n_perr + 1;
    if (p_rx_valid)   p_valid <= p_valid + 1;
    if (p_frame_err)  p_ferr  <= p_ferr + 1;
    if (p_parity_err) p_perr  <= p_perr + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr;
    bp_valid = p_valid; bp_ferr = p_ferr; bp_perr = p_perr;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input logic with_start);
    rx_line   = b;
    start_sig = with_start;
    repeat (CPB) begin
      @(posedge clk);
      #1;
      start_sig = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
    start_cycle = cycle;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive_bit(data[i], 1'b0);
    drive_bit(stop_bit, 1'b0);
  endtask

  task automatic send_parity_frame(input logic [7:0] data, input logic par_bit);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive_bit(data[i], 1'b0);
    drive_bit(par_bit, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_en     = 1'b1;
    rx_line   = 1'b1;
    start_sig = 1'b0;
    wait_cycles(3);
    check_output("reset_data",   32'(rx_data), 32'h00);
    check_output("reset_busy",   32'(busy), 32'h0);
    check_output("reset_valid",  32'(rx_valid), 32'h0);
    check_output("reset_ferr",   32'(frame_err), 32'h0);
    check_output("reset_perr",   32'(parity_err), 32'h0);
    rst_n = 1'b1;
    wait_cycles(4);

    $display("[TB] single frame 0xA5");
    snap();
    apply_stimulus(8'hA5, 1'b1);
    wait_cycles(20);
    check_output("a5_valid_cnt", 32'(n_valid - b_valid), 32'd1);
    check_output("a5_data",      32'(data_last), 32'hA5);
    check_output("a5_latency",   32'(valid_cycle - start_cycle), 32'd153);
    check_output("a5_ferr_cnt",  32'(n_ferr - b_ferr), 32'd0);
    check_output("a5_busy_idle", 32'(busy), 32'h0);

    $display("[TB] back-to-back 0x3C 0xC3");
    snap();
    apply_stimulus(8'h3C, 1'b1);
    apply_stimulus(8'hC3, 1'b1);
    wait_cycles(20);
    check_output("b2b_valid_cnt", 32'(n_valid - b_valid), 32'd2);
    check_output("b2b_first",     32'(data_prev), 32'h3C);
    check_output("b2b_second",    32'(data_last), 32'hC3);

    $display("[TB] bad stop then break");
    snap();
    apply_stimulus(8'h55, 1'b0);
    rx_line = 1'b0;
    wait_cycles(40 * CPB);
    check_output("brk_ferr_cnt",  32'(n_ferr - b_ferr), 32'd1);
    check_output("brk_valid_cnt", 32'(n_valid - b_valid), 32'd0);
    check_output("brk_perr_cnt",  32'(n_perr - b_perr), 32'd0);
    check_output("brk_data",      32'(rx_data), 32'h55);
    check_output("brk_busy",      32'(busy), 32'h0);
    rx_line = 1'b1;
    wait_cycles(3 * CPB);

    $display("[TB] start glitch");
    snap();
    rx_line   = 1'b0;
    start_sig = 1'b1;
    wait_cycles(1);
    start_sig = 1'b0;
    wait_cycles(2);
    check_output("glitch_busy_hi", 32'(busy), 32'h1);
    rx_line = 1'b1;
    wait_cycles(20);
    check_output("glitch_busy_lo", 32'(busy), 32'h0);
    check_output("glitch_pulses",  32'((n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr)), 32'd0);

    $display("[TB] even parity frames");
    snap();
    send_parity_frame(8'h07, 1'b1);
    wait_cycles(20);
    check_output("par_good_valid", 32'(p_valid - bp_valid), 32'd1);
    check_output("par_good_perr",  32'(p_perr - bp_perr), 32'd0);
    check_output("par_good_data",  32'(p_rx_data), 32'h07);
    snap();
    send_parity_frame(8'h07, 1'b0);
    wait_cycles(20);
    check_output("par_bad_perr",  32'(p_perr - bp_perr), 32'd1);
    check_output("par_bad_valid", 32'(p_valid - bp_valid), 32'd0);
    check_output("par_bad_ferr",  32'(p_ferr - bp_ferr), 32'd0);
    check_output("par_bad_data",  32'(p_rx_data), 32'h07);

    $display("[TB] enable drop during data bit 4");
    snap();
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    rx_line = 1'b1;
    wait_cycles(5);
    check_output("en_busy_before", 32'(busy), 32'h1);
    rx_en = 1'b0;
    wait_cycles(1);
    check_output("en_busy_after", 32'(busy), 32'h0);
    rx_en = 1'b1;
    wait_cycles(CPB - 6);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    wait_cycles(20);
    check_output("en_pulses", 32'((n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr)), 32'd0);
    check_output("en_data_kept", 32'(rx_data), 32'h07);
    check_output("en_busy_idle", 32'(busy), 32'h0);

    $display("[TB] reset during data bit 4");
    snap();
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    rx_line = 1'b1;
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_data", 32'(rx_data), 32'h00);
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(CPB - 6);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    wait_cycles(20);
    check_output("rst_pulses", 32'((n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr)), 32'd0);

    snap();
    apply_stimulus(8'h12, 1'b1);
    wait_cycles(20);
    check_output("post_valid_cnt", 32'(n_valid - b_valid), 32'd1);
    check_output("post_data",      32'(data_last), 32'h12);
    check_output("post_latency",   32'(valid_cycle - start_cycle), 32'd153);
    check_output("post_ferr_cnt",  32'(n_ferr - b_ferr), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial-to-parallel UART receive stage sitting directly downstream of the RX synchroniser/falling-edge detector.
- Consumes the synchronised line level and the one-cycle start pulse, times bit centres with a clock-divider counter, and assembles the data bits LSB first.
- Checks the optional parity bit and the stop bit, then presents the byte to the decoder input buffer with a one-cycle valid pulse or an error pulse.

Parameters:
- CLKS_PER_BIT, 434, i_clk cycles per UART bit; legal range is 4 or more.
- DATA_BITS, 8, data bits per frame; legal range is 5..9.
- PARITY_EN, 0, 1 inserts a parity bit between the data bits and the stop bit.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even parity; ignored when PARITY_EN=0.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_en  in  1  receiver enable; low aborts any frame and holds IDLE
- i_start_signal  in  1  one-cycle falling-edge pulse from the synchroniser stage
- i_rx_in  in  1  synchronised serial line; idle level is 1
- o_rx_data  out  DATA_BITS  last received word, bit 0 received first
- o_rx_valid  out  1  one-cycle pulse: frame good, o_rx_data updated
- o_frame_err  out  1  one-cycle pulse: stop bit sampled 0
- o_parity_err  out  1  one-cycle pulse: parity mismatch with a good stop bit
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE; all counters 0; o_rx_data 0; o_rx_valid, o_frame_err, o_parity_err, o_busy all 0.
- Counters:
  - Bit-timing counter width is $clog2(CLKS_PER_BIT).
  - HALF = CLKS_PER_BIT/2, integer division.
  - Bit index counter width is $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - i_start_signal=1 with i_rx_en=1 -> START; timing counter cleared.
  - All other inputs are ignored.
- START:
  - Counter increments each cycle.
  - At counter==HALF-1, sample i_rx_in.
  - Sample 0 -> DATA, counter cleared, bit index 0.
  - Sample 1 is a glitch -> IDLE, no output pulse.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample i_rx_in into shift register bit [index] and clear the counter.
  - After index DATA_BITS-1 is sampled -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - At counter==CLKS_PER_BIT-1, sample i_rx_in and compute mismatch.
  - Even parity requires XOR(data, parity bit)==0; odd parity requires 1.
  - Then -> STOP.
- STOP:
  - At counter==CLKS_PER_BIT-1, sample i_rx_in -> IDLE.
  - On the following cycle, exactly one pulse asserts, with priority: stop=0 gives o_frame_err; else a parity mismatch gives o_parity_err; else o_rx_valid.
  - o_rx_data is loaded from the shift register in the same cycle as the pulse, for every outcome, and holds until the next frame completes.
- Latency: o_rx_valid asserts (HALF + (DATA_BITS+PARITY_EN+1)*CLKS_PER_BIT + 1) cycles after the i_start_signal cycle.
- A start pulse during a non-IDLE state is ignored.
- Because of the single-cycle return through IDLE, a start pulse arriving on the cycle after the STOP sample is accepted (back-to-back frames).
- Break condition (line held low): o_frame_err pulses once. No retrigger occurs, because the upstream stage only pulses on a new falling edge.
- i_rx_en=0 in any state: synchronous return to IDLE next cycle, counters cleared, no pulses, o_rx_data unchanged.
- Reset asserted mid-frame clears everything immediately. After release the block waits for a new start pulse.
- o_busy is registered from state and is 1 during START..STOP.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT and DATA_BITS constants;
  - a parity function par_calc(data, odd).
- Sub-module uart_bit_timer is natural: a cycle counter with clear and two compare outputs, half_tick and full_tick.
- The FSM, shift register and checks stay in uart_rx_frame.

Test Plan:
- All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, with the detector stage instantiated upstream.
- Scenario 1: send 0xA5 with a good stop bit -> a single o_rx_valid pulse, o_rx_data=0xA5, 1+8+16*9 cycles after the start pulse; o_frame_err=0.
- Scenario 2: send 0x3C then 0xC3 back-to-back with no idle gap -> two valid pulses with data 0x3C and 0xC3, and no missed start.
- Scenario 3: send 0x55 with stop bit 0, then hold the line low for 40 bits -> exactly one o_frame_err pulse, o_rx_data=0x55, no o_rx_valid, and the FSM stays in IDLE until the next edge.
- Scenario 4: line goes low for 3 cycles then returns high -> START samples 1, the FSM returns to IDLE, o_busy falls, no pulses.
- Scenario 5: PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 1 -> o_rx_valid; send 0x07 with parity bit 0 -> o_parity_err.
- Scenario 6: drop i_rx_en (or assert i_rst_n low) during data bit 4 of 0xFF -> IDLE next cycle (immediately for reset), no pulses; a following frame 0x12 is received correctly.
